// File: rtl/result_seg7_scanner.sv
// -----------------------------------------------------------------------------
// result_seg7_scanner
//
// Shows a 32-bit result-register value as 8 hex digits on a multiplexed,
// common-anode 7-segment display. The value is captured into a shadow register
// under a load/hold handshake. A prescaled scan state machine lights one digit
// per slot. Each slot begins with a blanking interval so that the previous
// digit's segments do not ghost onto the next anode.
//
// Optional build macro:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, digits above the most
//   significant nonzero nibble of the shadow are suppressed. Digit 0 is always
//   shown.
//
// Parameters:
//   TICK_DIV     - clk cycles per digit slot (must be > BLANK_CYCLES)
//   BLANK_CYCLES - cycles at the start of each slot with all anodes off (>= 1)
//   NUM_DIGITS   - digits scanned (fixed at 8 for a 32-bit value)
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high; clears all state
//   value      - result-register value to display
//   load       - snapshot request (single-cycle or level)
//   hold       - freeze; while high, load is ignored
//   dp_mask    - decimal point enables, bit i for digit i
//   an         - anodes, active-low, an[i] selects digit i
//   seg        - segments {g,f,e,d,c,b,a}, active-low
//   dp_n       - decimal point, active-low
//   snap_valid - high once a snapshot has been taken since reset
// -----------------------------------------------------------------------------
module result_seg7_scanner #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        hold,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        snap_valid
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_e;

  state_e        state_q,      state_d;
  logic [PW-1:0] presc_q,      presc_d;
  logic [2:0]    digit_q,      digit_d;
  logic [31:0]   shadow_q,     shadow_d;
  logic          snap_valid_q, snap_valid_d;
  logic [7:0]    an_q,         an_d;
  logic [6:0]    seg_q,        seg_d;
  logic          dp_n_q,       dp_n_d;

  logic          presc_wrap;
  logic [4:0]    nib_base;
  logic [3:0]    nibble;
  logic          digit_lit;

  // Active-low hex decode for {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    presc_d      = presc_q;
    state_d      = state_q;
    digit_d      = digit_q;
    shadow_d     = shadow_q;
    snap_valid_d = snap_valid_q;
    an_d         = 8'hFF;
    seg_d        = 7'h7F;
    dp_n_d       = 1'b1;

    // Slot timing: the prescaler wrap ends a slot and opens the next digit's
    // blanking interval; the ON phase starts after BLANK_CYCLES.
    presc_wrap = (presc_q == PW'(TICK_DIV - 1));
    if (presc_wrap) begin
      presc_d = '0;
      state_d = ST_BLANK;
      digit_d = (digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      if (state_q == ST_BLANK && presc_q == PW'(BLANK_CYCLES - 1)) begin
        state_d = ST_ON;
      end
    end

    // Hold wins over load; the scan position is never disturbed by a snapshot.
    if (load && !hold) begin
      shadow_d     = value;
      snap_valid_d = 1'b1;
    end

    nib_base = {digit_q, 2'b00};
    nibble   = shadow_q[nib_base +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and everything above it are zero.
    digit_lit = (state_q == ST_ON) &&
                ((digit_q == 3'd0) || ((shadow_q >> nib_base) != 32'd0));
`else
    digit_lit = (state_q == ST_ON);
`endif

    if (digit_lit) begin
      an_d   = ~(8'h01 << digit_q);
      seg_d  = hex_to_seg(nibble);
      dp_n_d = ~dp_mask[digit_q];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      presc_q      <= '0;
      digit_q      <= 3'd0;
      shadow_q     <= 32'd0;
      snap_valid_q <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      snap_valid_q <= snap_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_result_seg7_scanner.sv
// -----------------------------------------------------------------------------
// tb_result_seg7_scanner
//
// Self-checking bench for result_seg7_scanner with TICK_DIV=8, BLANK_CYCLES=2.
// A behavioural model derives the expected display from the number of clock
// edges since reset release: the output slot is (n-1)/TICK_DIV, the position
// in the slot is (n-1)%TICK_DIV, and the first BLANK_CYCLES positions are
// dark. Directed literal checks pin the model to hand-computed values.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_result_seg7_scanner;

  localparam int T = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] value = 32'd0;
  logic        load = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        snap_valid;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  result_seg7_scanner #(
    .TICK_DIV    (T),
    .BLANK_CYCLES(B),
    .NUM_DIGITS  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .hold      (hold),
    .dp_mask   (dp_mask),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .snap_valid(snap_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          m_n      = 0;
  logic [31:0] m_shadow = 32'd0;
  logic        m_valid  = 1'b0;
  logic [7:0]  exp_an   = 8'hFF;
  logic [6:0]  exp_seg  = 7'h7F;
  logic        exp_dp_n = 1'b1;
  logic        exp_valid = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n       = 0;
      m_shadow  = 32'd0;
      m_valid   = 1'b0;
      exp_an    = 8'hFF;
      exp_seg   = 7'h7F;
      exp_dp_n  = 1'b1;
      exp_valid = 1'b0;
    end else begin
      int p, d;
      bit lit;
      logic [31:0] upper;
      m_n++;
      p     = (m_n - 1) % T;
      d     = ((m_n - 1) / T) % 8;
      upper = m_shadow >> (4 * d);
      lit   = (p >= B);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d != 0 && upper == 32'd0) lit = 1'b0;
`endif
      if (lit) begin
        exp_an   = ~(8'h01 << d);
        exp_seg  = seg_tab[upper[3:0]];
        exp_dp_n = ~dp_mask[d];
      end else begin
        exp_an   = 8'hFF;
        exp_seg  = 7'h7F;
        exp_dp_n = 1'b1;
      end
      if (load && !hold) begin
        m_shadow = value;
        m_valid  = 1'b1;
      end
      exp_valid = m_valid;
    end
  end

  // Compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("cyc_an",    {24'd0, an},         {24'd0, exp_an});
      check("cyc_seg",   {25'd0, seg},        {25'd0, exp_seg});
      check("cyc_dp_n",  {31'd0, dp_n},       {31'd0, exp_dp_n});
      check("cyc_valid", {31'd0, snap_valid}, {31'd0, exp_valid});
    end
  end

  // Wait (bounded) for a given anode pattern, sampled on the falling edge.
  task automatic wait_an(input logic [7:0] target, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (an === target) found = 1'b1;
    end
    if (!found) check({"timeout_", name}, {24'd0, an}, {24'd0, target});
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    #1 reset = 1'b1;
    run_cmp = 1'b1;
    run_cycles(2);
    check("rst_an",    {24'd0, an},         32'h0000_00FF);
    check("rst_seg",   {25'd0, seg},        32'h0000_007F);
    check("rst_dp_n",  {31'd0, dp_n},       32'd1);
    check("rst_valid", {31'd0, snap_valid}, 32'd0);
    reset = 1'b0;

    // Idle scan after reset: zeros everywhere, no snapshot yet.
    wait_an(8'hFE, "idle_d0");
    check("idle_d0_seg",   {25'd0, seg},        32'h40);
    check("idle_d0_valid", {31'd0, snap_valid}, 32'd0);
    run_cycles(70);

    // Single-cycle load of 0x0123ABCD.
    value = 32'h0123_ABCD;
    load  = 1'b1;
    run_cycles(1);
    load  = 1'b0;
    check("load_valid", {31'd0, snap_valid}, 32'd1);
    wait_an(8'hFE, "abcd_d0");
    check("abcd_d0_seg", {25'd0, seg}, 32'h21);
    wait_an(8'hF7, "abcd_d3");
    check("abcd_d3_seg", {25'd0, seg}, 32'h08);
    wait_an(8'hBF, "abcd_d6");
    check("abcd_d6_seg", {25'd0, seg}, 32'h79);
    run_cycles(70);

    // Hold beats load: previous pattern persists.
    hold  = 1'b1;
    value = 32'hFFFF_FFFF;
    load  = 1'b1;
    wait_an(8'hFB, "hold_d2");
    check("hold_d2_seg", {25'd0, seg}, 32'h03);
    run_cycles(20);

    // Drop hold with load still high.
    hold = 1'b0;
    run_cycles(1);
    wait_an(8'hFE, "ff_d0");
    check("ff_d0_seg", {25'd0, seg}, 32'h0E);
    load = 1'b0;
    run_cycles(70);

    // Decimal point on digit 2 only.
    dp_mask = 8'h04;
    wait_an(8'hFB, "dp_d2");
    check("dp_d2_dp_n", {31'd0, dp_n}, 32'd0);
    wait_an(8'hF7, "dp_d3");
    check("dp_d3_dp_n", {31'd0, dp_n}, 32'd1);
    run_cycles(70);

    // Asynchronous reset in the middle of digit 5's ON phase.
    wait_an(8'hDF, "mid_d5");
    #2 reset = 1'b1;
    #1;
    check("async_an",    {24'd0, an},         32'h0000_00FF);
    check("async_seg",   {25'd0, seg},        32'h0000_007F);
    check("async_dp_n",  {31'd0, dp_n},       32'd1);
    check("async_valid", {31'd0, snap_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_e1_an", {24'd0, an}, 32'h0000_00FF);
    @(negedge clk);
    check("rel_e2_an", {24'd0, an}, 32'h0000_00FF);
    @(negedge clk);
    check("rel_e3_an",  {24'd0, an},  32'h0000_00FE);
    check("rel_e3_seg", {25'd0, seg}, 32'h40);

    // Small value: digit 1 = A, digit 0 = 0; upper digits depend on the build.
    dp_mask = 8'h00;
    value   = 32'h0000_00A0;
    load    = 1'b1;
    run_cycles(1);
    load    = 1'b0;
    wait_an(8'hFD, "a0_d1");
    check("a0_d1_seg", {25'd0, seg}, 32'h08);
    wait_an(8'hFE, "a0_d0");
    check("a0_d0_seg", {25'd0, seg}, 32'h40);
    run_cycles(70);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
